// File: rtl/divider_iter_param.sv
// Radix-2 restoring iterative divider for RISC-V DIV/DIVU/REM/REMU and the W variants.
// Valid/ready on both sides; divide-by-zero and signed overflow complete in one cycle.
module divider_iter_param #(
  parameter int unsigned XLEN    = 64,
  parameter bit          WORD_EN = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            divw,
  input  logic            div_signed,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int unsigned     CW    = $clog2(XLEN);
  localparam int unsigned     ALIGN = XLEN - 32;
  localparam logic [XLEN-1:0] LO32  = XLEN'(64'hFFFF_FFFF);
  localparam logic [XLEN-1:0] WMIN  = XLEN'(64'h8000_0000);
  localparam logic [XLEN-1:0] XMIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] part_q, part_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            word_q, word_d;
  logic            sign_quo_q, sign_quo_d;
  logic            sign_rem_q, sign_rem_d;
  logic [XLEN-1:0] quotient_q, quotient_d;
  logic [XLEN-1:0] remainder_q, remainder_d;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return x[31] ? (x | ~LO32) : (x & LO32);
  endfunction

  logic            word_in, a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_res;
  logic            sh_hi, q_bit;
  logic [XLEN-1:0] sh_lo, part_step, quo_step, q_fix, r_fix;

  // Operand conditioning at accept: magnitudes plus early-out detection.
  always_comb begin
    word_in  = divw & WORD_EN;
    a_neg    = div_signed & (word_in ? dividend[31] : dividend[XLEN-1]);
    b_neg    = div_signed & (word_in ? divisor[31] : divisor[XLEN-1]);
    a_ext    = word_in ? (a_neg ? sext32(dividend) : (dividend & LO32)) : dividend;
    b_ext    = word_in ? (b_neg ? sext32(divisor) : (divisor & LO32)) : divisor;
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    a_res    = word_in ? sext32(dividend) : dividend;
    div_zero = (b_ext == '0);
    overflow = div_signed & (b_ext == '1) & (a_ext == (word_in ? sext32(WMIN) : XMIN));
  end

  // The W+1-bit working remainder is {sh_hi, sh_lo}; when sh_hi is set the
  // subtraction always succeeds and the result fits back into XLEN bits.
  always_comb begin
    sh_hi     = part_q[XLEN-1];
    sh_lo     = {part_q[XLEN-2:0], dvd_q[XLEN-1]};
    q_bit     = sh_hi | (sh_lo >= dvs_q);
    part_step = q_bit ? (sh_lo - dvs_q) : sh_lo;
    quo_step  = {quo_q[XLEN-2:0], q_bit};
    q_fix     = sign_quo_q ? -quo_step : quo_step;
    r_fix     = sign_rem_q ? -part_step : part_step;
    if (word_q) begin
      q_fix = sext32(q_fix);
      r_fix = sext32(r_fix);
    end
  end

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    part_d      = part_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    sign_quo_d  = sign_quo_q;
    sign_rem_d  = sign_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d     = word_in;
          sign_quo_d = a_neg ^ b_neg;
          sign_rem_d = a_neg;
          dvd_d      = word_in ? (a_mag << ALIGN) : a_mag;
          dvs_d      = b_mag;
          part_d     = '0;
          quo_d      = '0;
          cnt_d      = word_in ? CW'(31) : CW'(XLEN - 1);
          if (div_zero) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = a_res;
          end else if (overflow) begin
            state_d     = DONE;
            quotient_d  = a_res;
            remainder_d = '0;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d  = dvd_q << 1;
        part_d = part_step;
        quo_d  = quo_step;
        if (cnt_q == '0) begin
          state_d     = DONE;
          quotient_d  = q_fix;
          remainder_d = r_fix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          quotient_d  = '0;
          remainder_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      quotient_d  = '0;
      remainder_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      part_q      <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      word_q      <= 1'b0;
      sign_quo_q  <= 1'b0;
      sign_rem_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      part_q      <= part_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      sign_quo_q  <= sign_quo_d;
      sign_rem_q  <= sign_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
endmodule

// File: tb/tb_divider_iter_param.sv
// Self-checking bench for divider_iter_param (XLEN=64): directed ISA cases,
// handshake/flush/reset scenarios and random ops against a native-arithmetic model.
module tb_divider_iter_param;
  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, divw, div_signed;
  logic        busy, out_valid, out_ready;
  logic [63:0] dividend, divisor, quotient, remainder;
  int          n_cmp = 0;
  int          n_err = 0;

  divider_iter_param #(.XLEN(64), .WORD_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .divw(divw), .div_signed(div_signed),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] a, b;
    bit          w, s;
    logic [63:0] eq, er;
    int          lat;
  } op_t;

  // Reference: RISC-V division results from native SV arithmetic; returns latency.
  function automatic int model(input logic [63:0] a, input logic [63:0] b, input bit w,
                               input bit s, output logic [63:0] q, output logic [63:0] r);
    logic signed [31:0] sa32, sb32, q32, r32;
    logic        [31:0] ua32, ub32;
    logic signed [63:0] sa64, sb64;
    logic        [63:0] q64, r64;
    int lat;
    if (w) begin
      sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
      lat = 33;
      if (ub32 == 0) begin q32 = '1; r32 = sa32; lat = 1; end
      else if (s && sa32 == 32'sh8000_0000 && sb32 == -1) begin q32 = sa32; r32 = 0; lat = 1; end
      else if (s) begin q32 = sa32 / sb32; r32 = sa32 % sb32; end
      else begin q32 = ua32 / ub32; r32 = ua32 % ub32; end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      sa64 = a; sb64 = b;
      lat = 65;
      if (b == 0) begin q64 = '1; r64 = a; lat = 1; end
      else if (s && sa64 == 64'sh8000_0000_0000_0000 && sb64 == -1) begin q64 = a; r64 = 0; lat = 1; end
      else if (s) begin q64 = sa64 / sb64; r64 = sa64 % sb64; end
      else begin q64 = a / b; r64 = a % b; end
      q = q64;
      r = r64;
    end
    return lat;
  endfunction

  // Present one operation for a single accepting edge, then scramble the inputs.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input bit w, input bit s);
    dividend = a; divisor = b; divw = w; div_signed = s; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
    divw = 1'($urandom); div_signed = 1'($urandom);
  endtask

  // Count cycles since accept until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (quotient !== 64'h0) begin n_err++; $display("FAIL reset_quotient got %h want 0", quotient); end
    n_cmp++; if (remainder !== 64'h0) begin n_err++; $display("FAIL reset_remainder got %h want 0", remainder); end
  endtask

  task automatic test_directed();
    op_t ops[11];
    int  lat;
    ops[0]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    ops[1]  = '{64'hFFFF_FFFF_8000_0000, 64'd2, 1'b1, 1'b0, 64'h0000_0000_4000_0000, 64'h0, 33};
    ops[2]  = '{64'd123, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd123, 1};
    ops[3]  = '{64'h0000_0000_8000_0005, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, 1};
    ops[4]  = '{64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h0, 1};
    ops[5]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'h0, 1};
    ops[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 65};
    ops[7]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65};
    ops[8]  = '{64'h0000_0000_FFFF_FFF8, 64'd3, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    ops[9]  = '{64'h1234_5678_8000_0000, 64'hAAAA_0000_0000_0001, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'h0, 33};
    ops[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 65};
    foreach (ops[i]) begin
      start_op(ops[i].a, ops[i].b, ops[i].w, ops[i].s);
      if (ops[i].lat > 1) begin
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          n_err++; $display("FAIL dir%0d_busy got busy=%b in_ready=%b want 1/0", i, busy, in_ready);
        end
      end
      wait_done(lat);
      n_cmp++; if (lat !== ops[i].lat) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, ops[i].lat); end
      n_cmp++; if (quotient !== ops[i].eq) begin n_err++; $display("FAIL dir%0d_quotient got %h want %h", i, quotient, ops[i].eq); end
      n_cmp++; if (remainder !== ops[i].er) begin n_err++; $display("FAIL dir%0d_remainder got %h want %h", i, remainder, ops[i].er); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(64'd100, 64'd7, 1'b0, 1'b0);
    wait_done(lat);
    n_cmp++; if (lat !== 65) begin n_err++; $display("FAIL bp_latency got %0d want 65", lat); end
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 64'd14 || remainder !== 64'd2) begin
        n_err++;
        $display("FAIL bp_hold%0d got v=%b rdy=%b q=%0d r=%0d want 1/0/14/2", c, out_valid, in_ready, quotient, remainder);
      end
      @(posedge clock); #1;
    end
    consume();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 64'h0) begin
      n_err++; $display("FAIL bp_release got rdy=%b v=%b q=%h want 1/0/0", in_ready, out_valid, quotient);
    end
  endtask

  task automatic test_flush();
    int lat;
    start_op(64'h0123_4567_89AB_CDEF, 64'd12345, 1'b0, 1'b0);
    repeat (19) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_calc got rdy=%b busy=%b v=%b want 1/0/0", in_ready, busy, out_valid);
    end
    start_op(64'd10, 64'd3, 1'b0, 1'b1);
    wait_done(lat);
    n_cmp++; if (lat !== 65) begin n_err++; $display("FAIL flush_next_latency got %0d want 65", lat); end
    n_cmp++; if (quotient !== 64'd3) begin n_err++; $display("FAIL flush_next_quotient got %h want 3", quotient); end
    n_cmp++; if (remainder !== 64'd1) begin n_err++; $display("FAIL flush_next_remainder got %h want 1", remainder); end
    // Flush while holding a result.
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 64'h0 || remainder !== 64'h0) begin
      n_err++; $display("FAIL flush_done got v=%b rdy=%b q=%h r=%h want 0/1/0/0", out_valid, in_ready, quotient, remainder);
    end
    // Flush in IDLE blocks a coincident request.
    dividend = 64'd5; divisor = 64'd0; divw = 1'b0; div_signed = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL flush_idle got v=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    start_op(64'd999, 64'd7, 1'b0, 1'b0);
    repeat (9) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || quotient !== 64'h0 || remainder !== 64'h0) begin
      n_err++; $display("FAIL reset_calc got rdy=%b busy=%b v=%b q=%h r=%h", in_ready, busy, out_valid, quotient, remainder);
    end
    start_op(64'd9, 64'd0, 1'b0, 1'b0);
    wait_done(lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL reset_done_latency got %0d want 1", lat); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 64'h0 || remainder !== 64'h0) begin
      n_err++; $display("FAIL reset_done got rdy=%b v=%b q=%h r=%h", in_ready, out_valid, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(64'd10, 64'd3, 1'b0, 1'b0);
    wait_done(lat);
    n_cmp++; if (quotient !== 64'd3 || remainder !== 64'd1) begin n_err++; $display("FAIL b2b_first got q=%h r=%h want 3/1", quotient, remainder); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_in_done got %b want 0", in_ready); end
    out_ready = 1'b1; in_valid = 1'b1;
    dividend = 64'd77; divisor = 64'd0; divw = 1'b0; div_signed = 1'b0;
    @(posedge clock); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_no_same_cycle got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || quotient !== 64'hFFFF_FFFF_FFFF_FFFF || remainder !== 64'd77) begin
      n_err++; $display("FAIL b2b_second got v=%b q=%h r=%h want 1/ffffffffffffffff/4d", out_valid, quotient, remainder);
    end
    consume();
  endtask

  task automatic test_random();
    logic [63:0] a, b, eq, er;
    bit          w, s;
    int          mode, elat, lat, hold;
    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 5);
      w = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case (mode)
        0: if (w) b[31:0] = '0; else b = '0;
        1: begin
          s = 1'b1;
          if (w) begin a[31:0] = 32'h8000_0000; b[31:0] = '1; end
          else begin a = 64'h8000_0000_0000_0000; b = '1; end
        end
        2: begin
          b = 64'($urandom_range(1, 15));
          if (s && $urandom_range(0, 1) == 1) b = -b;
        end
        3: a = 64'($urandom_range(0, 1000));
        default: ;
      endcase
      elat = model(a, b, w, s, eq, er);
      start_op(a, b, w, s);
      wait_done(lat);
      n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, elat); end
      n_cmp++; if (quotient !== eq) begin n_err++; $display("FAIL rnd%0d_quotient a=%h b=%h w=%b s=%b got %h want %h", i, a, b, w, s, quotient, eq); end
      n_cmp++; if (remainder !== er) begin n_err++; $display("FAIL rnd%0d_remainder a=%h b=%h w=%b s=%b got %h want %h", i, a, b, w, s, remainder, er); end
      hold = $urandom_range(0, 3);
      if (hold > 0) begin
        repeat (hold) begin @(posedge clock); #1; end
        n_cmp++;
        if (out_valid !== 1'b1 || quotient !== eq || remainder !== er) begin
          n_err++; $display("FAIL rnd%0d_hold got v=%b q=%h r=%h want 1/%h/%h", i, out_valid, quotient, remainder, eq, er);
        end
      end
      consume();
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0; divw = 1'b0; div_signed = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/divider_iter_param.md
Name: divider_iter_param

Overview:
- Parametrised radix-2 restoring iterative divider for the EXU.
- Serves RISC-V DIV/DIVU/REM/REMU and the word variants DIVW/DIVUW/REMW/REMUW.
- Generalises the current fixed 64/32-bit divider:
  - XLEN parameter;
  - full valid/ready handshake on both input and output, with result hold under backpressure;
  - early completion for divide-by-zero and signed overflow, with ISA-defined results;
  - explicit flush.

Parameters:
- XLEN, 64, datapath width (32 or 64).
- WORD_EN, 1, enables divw mode (32-bit ops sign-extended to XLEN); when 0, divw is ignored.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill in-flight or held operation
- in_valid  in  1  operands valid
- in_ready  out  1  divider idle, can accept
- dividend  in  XLEN  dividend
- divisor  in  XLEN  divisor
- divw  in  1  32-bit word operation
- div_signed  in  1  signed operation
- busy  out  1  iteration in progress
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  XLEN  quotient
- remainder  out  XLEN  remainder

Behaviour:
- Clock is clock; reset is reset, synchronous, active-high.
- Reset state: state=IDLE. Outputs: in_ready=1, busy=0, out_valid=0, quotient=0, remainder=0.
- States are IDLE, CALC and DONE.
- in_ready=1 only in IDLE. busy=1 only in CALC. out_valid=1 only in DONE.
- Accept: in_valid & in_ready & ~flush in cycle T. Operands, divw and div_signed are captured. Inputs are don't-care afterwards.
- Operand width W = 32 when divw & WORD_EN, else XLEN. Word mode uses bits [31:0] only.
- Signed mode: operands are converted to magnitudes.
  - sign_q = sign(dividend) ^ sign(divisor)
  - sign_r = sign(dividend)
  - Unsigned mode: both signs are 0.
- Special cases, decided at accept; state goes IDLE->DONE directly, out_valid at T+1:
  - divisor[W-1:0]==0: quotient = all-ones(W); remainder = dividend[W-1:0].
  - signed & dividend == -2^(W-1) & divisor == -1: quotient = dividend[W-1:0]; remainder = 0.
- Normal case: IDLE->CALC.
  - W iterations, one quotient bit per cycle, MSB first.
  - Partial remainder is W+1 bits.
  - Each cycle: shift in the next dividend bit; if partial >= divisor, subtract and set the q bit.
  - Iteration counter runs from W-1 down to 0.
  - Final sign fix-up is registered in the transition to DONE.
  - out_valid is asserted at cycle T+W+1 (33 for word ops, 65 for XLEN=64 ops).
- Word mode: quotient and remainder are sign-extended from bit 31 to XLEN. This also applies to DIVUW/REMUW.
- DONE: outputs are held stable while out_valid & ~out_ready.
  - Handshake out_valid & out_ready moves DONE->IDLE next cycle.
  - in_ready rises next cycle; there is no same-cycle re-accept.
- flush is sampled in every state and takes priority over everything. The next state is IDLE:
  - In CALC: the result is discarded.
  - In DONE: out_valid drops next cycle; the result is discarded.
  - In IDLE: a coincident in_valid is not accepted.
- Simultaneous out_ready and flush in DONE: flush semantics apply, but the cycle still counts as a completed handshake from the consumer's side.
- quotient/remainder are 0 whenever out_valid=0. They are registered, not combinational.
- Reset mid-CALC or mid-DONE: returns to IDLE next cycle, all outputs at reset values.
- Remainder sign always follows the dividend. Invariant: dividend = q*divisor + r and |r| < |divisor|.

Test Plan:
- Signed 64-bit, dividend=-7, divisor=2, out_ready=1 -> out_valid at T+65; quotient=-3 (0xFFFF_FFFF_FFFF_FFFD); remainder=-1.
- DIVUW, dividend=0xFFFF_FFFF_8000_0000, divisor=2 -> out_valid at T+33; quotient=0x0000_0000_4000_0000; remainder=0.
- Divide-by-zero, signed 64, dividend=123, divisor=0 -> out_valid at T+1; quotient=0xFFFF_FFFF_FFFF_FFFF; remainder=123. Word mode, dividend=0x8000_0005, divisor=0 -> remainder=0xFFFF_FFFF_8000_0005.
- Overflow DIVW, dividend=0x8000_0000, divisor=-1 -> out_valid at T+1; quotient=0xFFFF_FFFF_8000_0000; remainder=0.
- Backpressure: unsigned 100/7 with out_ready=0 for 10 cycles after out_valid -> quotient=14 and remainder=2 stay stable, in_ready=0 throughout; out_ready=1 -> in_ready=1 next cycle.
- Flush at T+20 of a 64-bit op -> IDLE next cycle, no out_valid. A new op, 10/3 signed, accepted the following cycle -> quotient=3, remainder=1. Reset at T+10 -> all outputs at reset values next cycle.
